// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS receive channel: control-token symbol alignment and 10b->8b decode
//
// Purpose: hunts the raw deserialized stream for control tokens at each of the
// ten possible bit offsets, locks onto the offset that repeatedly carries
// tokens, and decodes aligned symbols into video bytes or 2-bit control values.
// One instance per channel; on the blue channel control_out carries {vs,hs}.
//
// Parameters:
//   LOCK_COUNT    consecutive aligned tokens needed to declare lock (>=1)
//   UNLOCK_COUNT  consecutive tokens at a foreign offset before lock is dropped (>=1)
//
// Ports:
//   clk_in         pixel clock
//   rst_n_in       synchronous reset, active-low
//   valid_in       data_in holds a new raw word this cycle
//   data_in        raw 10-bit word, bit 0 received first
//   valid_out      decoded outputs updated this cycle (valid_in delayed by one)
//   data_out       decoded video byte
//   control_out    decoded control bits
//   ve_out         1 = video data symbol, 0 = control token
//   locked_out     alignment locked
//   offset_out     current symbol offset, 0-9
//   err_count_out  alignment error count
//
// Optional feature macro: TMDS_DEC_ERR_CNT_EN
//   defined   - err_count_out counts lock losses and failed verifications (saturating)
//   undefined - err_count_out is tied to zero

module tmds_decoder #(
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        valid_in,
    input  logic [9:0]  data_in,
    output logic        valid_out,
    output logic [7:0]  data_out,
    output logic [1:0]  control_out,
    output logic        ve_out,
    output logic        locked_out,
    output logic [3:0]  offset_out,
    output logic [15:0] err_count_out
);

    localparam int HW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state;
    logic [9:0]      prev_word;
    logic [HW-1:0]   hit_cnt;
    logic [MW-1:0]   miss_cnt;

    // Returns {is_token, value}
    function automatic logic [2:0] token_lookup(input logic [9:0] c);
        case (c)
            10'b1101010100: token_lookup = 3'b100;
            10'b0010101011: token_lookup = 3'b101;
            10'b0101010100: token_lookup = 3'b110;
            10'b1010101011: token_lookup = 3'b111;
            default:        token_lookup = 3'b000;
        endcase
    endfunction

    logic [19:0]   win;
    logic [2:0]    lk [10];
    logic          any_hit;
    logic [3:0]    first_k;
    logic [9:0]    w;
    logic [2:0]    w_lk;
    logic [7:0]    d_unx;
    logic [7:0]    dec;
    logic          hit_last;
    logic [HW-1:0] hit_inc;
    logic          miss_last;
    logic [MW-1:0] miss_inc;

    always_comb begin
        win     = {data_in, prev_word};
        any_hit = 1'b0;
        first_k = 4'd0;
        w       = win[9:0];
        // Scan downwards so the lowest hitting offset is the one left standing
        for (int k = 9; k >= 0; k--) begin
            lk[k] = token_lookup(win[k +: 10]);
            if (lk[k][2]) begin
                any_hit = 1'b1;
                first_k = 4'(k);
            end
        end
        for (int k = 0; k < 10; k++) begin
            if (offset_out == 4'(k)) begin
                w = win[k +: 10];
            end
        end
        w_lk = token_lookup(w);

        // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8)
        d_unx  = w[9] ? ~w[7:0] : w[7:0];
        dec[0] = d_unx[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = w[8] ? (d_unx[i] ^ d_unx[i-1]) : ~(d_unx[i] ^ d_unx[i-1]);
        end

        hit_last  = (hit_cnt >= HW'(LOCK_COUNT - 1));
        hit_inc   = hit_last ? HW'(LOCK_COUNT) : hit_cnt + HW'(1);
        miss_last = (miss_cnt >= MW'(UNLOCK_COUNT - 1));
        miss_inc  = miss_last ? MW'(UNLOCK_COUNT) : miss_cnt + MW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state       <= SEARCH;
            prev_word   <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            control_out <= '0;
            ve_out      <= 1'b0;
            locked_out  <= 1'b0;
            offset_out  <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                prev_word <= data_in;

                // Decode is gated on the state before this word's transition
                if (state == LOCKED && w_lk[2]) begin
                    data_out    <= '0;
                    control_out <= w_lk[1:0];
                    ve_out      <= 1'b0;
                end else if (state == LOCKED) begin
                    data_out    <= dec;
                    control_out <= '0;
                    ve_out      <= 1'b1;
                end else begin
                    data_out    <= '0;
                    control_out <= '0;
                    ve_out      <= 1'b0;
                end

                case (state)
                    SEARCH: begin
                        if (any_hit) begin
                            offset_out <= first_k;
                            hit_cnt    <= HW'(1);
                            if (LOCK_COUNT == 1) begin
                                state      <= LOCKED;
                                locked_out <= 1'b1;
                                miss_cnt   <= '0;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (w_lk[2]) begin
                            hit_cnt <= hit_inc;
                            if (hit_last) begin
                                state      <= LOCKED;
                                locked_out <= 1'b1;
                                miss_cnt   <= '0;
                            end
                        end else begin
                            state   <= SEARCH;
                            hit_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (w_lk[2]) begin
                            miss_cnt <= '0;
                        end else if (any_hit) begin
                            // Tokens keep arriving, but not where we locked
                            if (miss_last) begin
                                state      <= SEARCH;
                                locked_out <= 1'b0;
                                miss_cnt   <= '0;
                                hit_cnt    <= '0;
                            end else begin
                                miss_cnt <= miss_inc;
                            end
                        end
                    end
                    default: begin
                        state      <= SEARCH;
                        locked_out <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TMDS_DEC_ERR_CNT_EN
    logic lock_lost;

    assign lock_lost = valid_in && !w_lk[2] &&
                       ((state == VERIFY) || (state == LOCKED && any_hit && miss_last));

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            err_count_out <= '0;
        end else if (lock_lost && err_count_out != 16'hFFFF) begin
            err_count_out <= err_count_out + 16'd1;
        end
    end
`else
    assign err_count_out = '0;
`endif

endmodule
